// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared deserializer word width, K28.5 comma patterns and FSM state type
package serdes_pkg;

    localparam int WORD_W = 10;
    localparam logic [WORD_W-1:0] COMMA_P = 10'b0011111010;
    localparam logic [WORD_W-1:0] COMMA_N = 10'b1100000101;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SYNC,
        LOCK
    } deser_state_t;

endpackage

// File: rtl/comma_det.sv
// rtl/comma_det.sv - combinational K28.5 detector over the SIPO window, either running disparity
module comma_det #(
    parameter int                WORD_W  = serdes_pkg::WORD_W,
    parameter logic [WORD_W-1:0] COMMA_P = serdes_pkg::COMMA_P,
    parameter logic [WORD_W-1:0] COMMA_N = serdes_pkg::COMMA_N
) (
    input  logic [WORD_W-1:0] par_in,
    output logic              match
);

    assign match = (par_in == COMMA_P) || (par_in == COMMA_N);

endmodule

// File: rtl/deser_ctrl.sv
// rtl/deser_ctrl.sv - comma hunt/sync/lock controller with a 1-entry aligned word register
// Define DESER_CTRL_STATS_EN to build the saturating lock-loss counter behind realign_cnt.
module deser_ctrl #(
    parameter int                WORD_W     = serdes_pkg::WORD_W,
    parameter logic [WORD_W-1:0] COMMA_P    = serdes_pkg::COMMA_P,
    parameter logic [WORD_W-1:0] COMMA_N    = serdes_pkg::COMMA_N,
    parameter int                LOCK_CNT   = 4,
    parameter int                LOSS_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              sipo_shift_en,
    input  logic [WORD_W-1:0] par_in,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              locked,
    output logic              overflow,
    output logic [7:0]        realign_cnt
);
    import serdes_pkg::*;

    localparam int CC_W = $clog2(LOCK_CNT + 1);

    deser_state_t      state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [CC_W-1:0]   comma_cnt_q, comma_cnt_d;
    logic [6:0]        loss_cnt_q, loss_cnt_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic              overflow_q, overflow_d;
    logic              match, boundary, load;

    comma_det #(
        .WORD_W  (WORD_W),
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_comma_det (
        .par_in (par_in),
        .match  (match)
    );

    assign boundary = (bit_cnt_q == 4'(WORD_W - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        load        = 1'b0;
        if (state_q == SYNC || state_q == LOCK) begin
            bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = HUNT;
            end
            HUNT: begin
                // A hit here defines the word phase: the next word ends WORD_W cycles later.
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
                if (match) begin
                    comma_cnt_d = CC_W'(1);
                    state_d     = SYNC;
                end
            end
            SYNC: begin
                if (match && !boundary) begin
                    comma_cnt_d = '0;
                    state_d     = HUNT;
                end else if (match) begin
                    comma_cnt_d = comma_cnt_q + CC_W'(1);
                    if (int'(comma_cnt_q) + 1 >= LOCK_CNT) state_d = LOCK;
                end
            end
            LOCK: begin
                if (boundary) begin
                    load = 1'b1;
                    if (match) begin
                        loss_cnt_d = '0;
                    end else if (int'(loss_cnt_q) + 1 >= LOSS_WORDS) begin
                        loss_cnt_d = '0;
                        state_d    = HUNT;
                    end else begin
                        loss_cnt_d = loss_cnt_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            comma_cnt_d = '0;
            loss_cnt_d  = '0;
        end
    end

    // A word that arrives while the held one is stalled is lost; the held one is never replaced.
    always_comb begin
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        overflow_d   = overflow_q;
        if (load && (!word_valid_q || word_ready)) begin
            word_valid_d = 1'b1;
            word_data_d  = par_in;
        end else if (load) begin
            overflow_d = 1'b1;
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            comma_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            comma_cnt_q  <= comma_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef DESER_CTRL_STATS_EN
    logic [7:0] realign_q, realign_d;

    always_comb begin
        realign_d = realign_q;
        if (state_q == LOCK && state_d == HUNT && realign_q != 8'hFF) begin
            realign_d = realign_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) realign_q <= '0;
        else     realign_q <= realign_d;
    end

    assign realign_cnt = realign_q;
`else
    assign realign_cnt = '0;
`endif

    assign sipo_shift_en = (state_q != IDLE);
    assign locked        = (state_q == LOCK);
    assign word_valid    = word_valid_q;
    assign word_data     = word_data_q;
    assign overflow      = overflow_q;

endmodule
